// File: rtl/act_data_loader_pkg.sv
// ============================================================================
//  Module   : act_data_loader_pkg
//  Purpose  : Shared widths, FSM encoding and address helper for the loaders.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package act_data_loader_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int FEAT_W = 16;
    localparam int DIM_W  = 11;

    localparam logic signed [DATA_W:0] SAT_MAX = 33'sd32767;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LB   = 3'd1,
        S_LIF  = 3'd2,
        S_SOF  = 3'd3,
        S_DONE = 3'd4,
        S_END  = 3'd5
    } state_t;

    // Word offset of element (c,h,w) in a channel-major feature map, mod 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] elem_off(
        input logic [DIM_W-1:0] c,
        input logic [DIM_W-1:0] h,
        input logic [DIM_W-1:0] w,
        input logic [DIM_W-1:0] hh,
        input logic [DIM_W-1:0] ww
    );
        logic [ADDR_W-1:0] cx, hx, wx, hhx, wwx;
        cx  = {{(ADDR_W-DIM_W){1'b0}}, c};
        hx  = {{(ADDR_W-DIM_W){1'b0}}, h};
        wx  = {{(ADDR_W-DIM_W){1'b0}}, w};
        hhx = {{(ADDR_W-DIM_W){1'b0}}, hh};
        wwx = {{(ADDR_W-DIM_W){1'b0}}, ww};
        return cx * hhx * wwx + hx * wwx + wx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/act_quant.sv
// ============================================================================
//  Module   : act_quant
//  Purpose  : Bias add, arithmetic right shift, ReLU and 16-bit saturation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_quant
    import act_data_loader_pkg::*;
(
    input  logic [DATA_W-1:0] acc,
    input  logic [FEAT_W-1:0] bias,
    input  logic [4:0]        shift,
    output logic [FEAT_W-1:0] y
);

    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] shifted;

    // One guard bit keeps accumulator + bias exact before the shift.
    always_comb begin
        sum     = $signed({acc[DATA_W-1], acc})
                + $signed({{(DATA_W-FEAT_W+1){bias[FEAT_W-1]}}, bias});
        shifted = sum >>> shift;
        y       = shifted[FEAT_W-1:0];
        if (shifted[DATA_W]) begin
            y = '0;
        end else if (shifted > SAT_MAX) begin
            y = 16'h7FFF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/act_data_loader.sv
// ============================================================================
//  Module   : act_data_loader
//  Purpose  : Streams conv accumulators through act_quant into activation memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_data_loader
    import act_data_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  C,
    input  logic [DIM_W-1:0]  H,
    input  logic [DIM_W-1:0]  W,
    input  logic [ADDR_W:0]   ifaddr,
    input  logic [ADDR_W:0]   baddr,
    input  logic [ADDR_W:0]   ofaddr,
    input  logic [4:0]        shift,
    output logic              rvalid,
    input  logic              rready,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              wvalid,
    input  logic              wready,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              done
);

    state_t            state;
    logic [DIM_W-1:0]  c, h, w;
    logic [DIM_W-1:0]  nc, nh, nw;
    logic [FEAT_W-1:0] bias;
    logic [FEAT_W-1:0] y;
    logic              chan_change;
    logic              last_elem;
    logic [ADDR_W-1:0] cur_off, nxt_off;
    logic              unused_addr_msb;

    // Sums wrap at ADDR_W bits, so the top address bit never contributes.
    assign unused_addr_msb = ^{ifaddr[ADDR_W], baddr[ADDR_W], ofaddr[ADDR_W]};

    act_quant u_quant (
        .acc   (rdata),
        .bias  (bias),
        .shift (shift),
        .y     (y)
    );

    always_comb begin
        nw          = w + 11'd1;
        nh          = h;
        nc          = c;
        chan_change = 1'b0;
        last_elem   = 1'b0;
        if (w == W - 11'd1) begin
            nw = '0;
            nh = h + 11'd1;
            if (h == H - 11'd1) begin
                nh          = '0;
                nc          = c + 11'd1;
                chan_change = 1'b1;
                last_elem   = (c == C - 11'd1);
            end
        end
        cur_off = elem_off(c, h, w, H, W);
        nxt_off = elem_off(nc, nh, nw, H, W);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            rvalid <= 1'b0;
            wvalid <= 1'b0;
            raddr  <= '0;
            waddr  <= '0;
            wdata  <= '0;
            done   <= 1'b0;
            c      <= '0;
            h      <= '0;
            w      <= '0;
            bias   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (C == '0 || H == '0 || W == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rvalid <= 1'b1;
                        raddr  <= baddr[ADDR_W-1:0] + {{(ADDR_W-DIM_W){1'b0}}, c};
                        state  <= S_LB;
                    end
                end
                // rvalid stays high: the bias handshake rolls straight into the element read.
                S_LB: begin
                    if (rready) begin
                        bias  <= rdata[FEAT_W-1:0];
                        raddr <= ifaddr[ADDR_W-1:0] + cur_off;
                        state <= S_LIF;
                    end
                end
                S_LIF: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        wvalid <= 1'b1;
                        waddr  <= ofaddr[ADDR_W-1:0] + cur_off;
                        wdata  <= {{(DATA_W-FEAT_W){1'b0}}, y};
                        state  <= S_SOF;
                    end
                end
                S_SOF: begin
                    if (wready) begin
                        wvalid <= 1'b0;
                        c      <= nc;
                        h      <= nh;
                        w      <= nw;
                        if (last_elem) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (chan_change) begin
                            rvalid <= 1'b1;
                            raddr  <= baddr[ADDR_W-1:0] + {{(ADDR_W-DIM_W){1'b0}}, nc};
                            state  <= S_LB;
                        end else begin
                            rvalid <= 1'b1;
                            raddr  <= ifaddr[ADDR_W-1:0] + nxt_off;
                            state  <= S_LIF;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_END;
                end
                S_END: begin
                    state <= S_END;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_act_data_loader.sv
// ============================================================================
//  Module   : tb_act_data_loader
//  Purpose  : Scoreboard bench for act_data_loader with a stalling memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_act_data_loader;
    import act_data_loader_pkg::*;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] C = '0, H = '0, W = '0;
    logic [26:0] ifaddr = '0, baddr = '0, ofaddr = '0;
    logic [4:0]  shift = '0;
    logic        rvalid, rready = 1'b0;
    logic [25:0] raddr;
    logic [31:0] rdata = '0;
    logic        wvalid, wready = 1'b0;
    logic [25:0] waddr;
    logic [31:0] wdata;
    logic        done;

    act_data_loader dut (
        .clk(clk), .rst(rst), .C(C), .H(H), .W(W),
        .ifaddr(ifaddr), .baddr(baddr), .ofaddr(ofaddr), .shift(shift),
        .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .done(done)
    );

    always #5 clk = ~clk;

    int  chk_cnt = 0, err_cnt = 0;
    int  reads, writes, done_cnt, cyc = 0, done_cyc, rel_cyc;
    bit  stall_en = 0, hold_w = 0;
    logic [31:0] mem [logic [25:0]];
    logic [25:0] rd_q[$];
    wr_t         wr_q[$];
    logic [31:0] acc_v[$];
    logic [15:0] bias_v[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_q(logic [31:0] acc, logic [15:0] b, int sh);
        longint s, t;
        s = longint'($signed(acc)) + longint'($signed(b));
        t = s >>> sh;
        if (t < 0) return 16'h0000;
        if (t > 32767) return 16'h7FFF;
        return t[15:0];
    endfunction

    task automatic build_expect();
        int i;
        logic [26:0] sum;
        wr_t e;
        mem.delete(); rd_q.delete(); wr_q.delete();
        i = 0;
        for (int cc = 0; cc < int'(C); cc++) begin
            sum = baddr + 27'(cc);
            rd_q.push_back(sum[25:0]);
            mem[sum[25:0]] = {16'hA5C3, bias_v[cc]};
            for (int hh = 0; hh < int'(H); hh++) begin
                for (int ww = 0; ww < int'(W); ww++) begin
                    sum = ifaddr + 27'(i);
                    rd_q.push_back(sum[25:0]);
                    mem[sum[25:0]] = acc_v[i];
                    sum = ofaddr + 27'(i);
                    e.addr = sum[25:0];
                    e.data = {16'h0000, model_q(acc_v[i], bias_v[cc], int'(shift))};
                    wr_q.push_back(e);
                    i++;
                end
            end
        end
    endtask

    task automatic run_layer(input int budget, output bit timed_out);
        rst = 1'b0; reads = 0; writes = 0; done_cnt = 0; done_cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (8) @(negedge clk);
    endtask

    // Memory responder and protocol monitor
    initial begin : monitor
        bit          prev_rstall = 0, prev_wstall = 0;
        logic [25:0] prev_raddr, prev_waddr, exp_ra;
        logic [31:0] prev_wdata;
        int          rwait = 0, wwait = 0;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rready = 1'b0; wready = 1'b0;
                prev_rstall = 0; prev_wstall = 0;
                rwait = 0; wwait = 0;
            end else begin
                chk_cnt++;
                if (rvalid && wvalid) begin
                    err_cnt++; $display("FAIL overlap: rvalid=%b wvalid=%b, required not both", rvalid, wvalid);
                end
                if (prev_rstall) begin
                    chk_cnt++;
                    if (rvalid !== 1'b1 || raddr !== prev_raddr) begin
                        err_cnt++; $display("FAIL rd_stable: rvalid=%b raddr=%h, required 1 %h", rvalid, raddr, prev_raddr);
                    end
                end
                if (prev_wstall) begin
                    chk_cnt++;
                    if (wvalid !== 1'b1 || waddr !== prev_waddr || wdata !== prev_wdata) begin
                        err_cnt++; $display("FAIL wr_stable: wvalid=%b waddr=%h wdata=%h, required 1 %h %h", wvalid, waddr, wdata, prev_waddr, prev_wdata);
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                rready = 1'b0; wready = 1'b0;
                if (rvalid === 1'b1) begin
                    if (rwait > 0) rwait--;
                    else begin
                        rready = 1'b1;
                        rdata  = mem.exists(raddr) ? mem[raddr] : 32'hDEAD_BEEF;
                        reads++;
                        chk_cnt++;
                        if (rd_q.size() == 0) begin
                            err_cnt++; $display("FAIL rd_addr: raddr=%h, required no read", raddr);
                        end else begin
                            exp_ra = rd_q.pop_front();
                            if (raddr !== exp_ra) begin
                                err_cnt++; $display("FAIL rd_addr: raddr=%h, required %h", raddr, exp_ra);
                            end
                        end
                        rwait = stall_en ? $urandom_range(0, 5) : 0;
                    end
                end
                if (wvalid === 1'b1 && !hold_w) begin
                    if (wwait > 0) wwait--;
                    else begin
                        wready = 1'b1;
                        writes++;
                        chk_cnt++;
                        if (wr_q.size() == 0) begin
                            err_cnt++; $display("FAIL wr_data: waddr=%h wdata=%h, required no write", waddr, wdata);
                        end else begin
                            e = wr_q.pop_front();
                            if (waddr !== e.addr || wdata !== e.data) begin
                                err_cnt++; $display("FAIL wr_data: waddr=%h wdata=%h, required %h %h", waddr, wdata, e.addr, e.data);
                            end
                        end
                        wwait = stall_en ? $urandom_range(0, 5) : 0;
                    end
                end
                prev_rstall = rvalid && !rready;
                prev_wstall = wvalid && !wready;
                prev_raddr  = raddr;
                prev_waddr  = waddr;
                prev_wdata  = wdata;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; C = 11'd3; H = 11'd3; W = 11'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({rvalid, wvalid, done} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_flags: rvalid/wvalid/done=%b, required 000", {rvalid, wvalid, done});
        end
        chk_cnt++;
        if (raddr !== '0 || waddr !== '0 || wdata !== '0) begin
            err_cnt++; $display("FAIL reset_bus: raddr=%h waddr=%h wdata=%h, required 0 0 0", raddr, waddr, wdata);
        end
    endtask

    task automatic test_basic();
        bit to;
        C = 11'd1; H = 11'd2; W = 11'd2; shift = 5'd0;
        ifaddr = 27'h0001000; baddr = 27'h0000100; ofaddr = 27'h0002000;
        bias_v = '{16'h0000};
        acc_v  = '{32'd5, -32'sd3, 32'd40000, 32'd0};
        build_expect();
        run_layer(500, to);
        chk_cnt++;
        if (to) begin err_cnt++; $display("FAIL basic_timeout: done not seen, required within 500 cycles"); end
        chk_cnt++;
        if (writes != 4 || reads != 5) begin
            err_cnt++; $display("FAIL basic_counts: writes=%0d reads=%0d, required 4 5", writes, reads);
        end
        chk_cnt++;
        if (done_cnt != 1 || wr_q.size() != 0) begin
            err_cnt++; $display("FAIL basic_done: done pulses=%0d pending writes=%0d, required 1 0", done_cnt, wr_q.size());
        end
    endtask

    task automatic test_bias_per_channel();
        bit to;
        C = 11'd2; H = 11'd1; W = 11'd1; shift = 5'd2;
        ifaddr = 27'h0003000; baddr = 27'h0000200; ofaddr = 27'h0004000;
        bias_v = '{16'd100, 16'hFF9C};
        acc_v  = '{32'd3, 32'd7};
        build_expect();
        run_layer(500, to);
        chk_cnt++;
        if (to || done_cnt != 1) begin
            err_cnt++; $display("FAIL bias_done: timeout=%b pulses=%0d, required 0 1", to, done_cnt);
        end
        chk_cnt++;
        if (writes != 2 || reads != 4 || rd_q.size() != 0) begin
            err_cnt++; $display("FAIL bias_counts: writes=%0d reads=%0d pending=%0d, required 2 4 0", writes, reads, rd_q.size());
        end
    endtask

    task automatic test_stall();
        bit to;
        C = 11'd2; H = 11'd2; W = 11'd3; shift = 5'($urandom_range(0, 20));
        ifaddr = 27'h4FFFFF0; baddr = 27'h0000300; ofaddr = 27'h7FFFFF8;
        bias_v.delete(); acc_v.delete();
        for (int i = 0; i < 2; i++) bias_v.push_back(16'($urandom));
        for (int i = 0; i < 12; i++) acc_v.push_back($urandom);
        acc_v[0] = 32'h8000_0000;
        build_expect();
        stall_en = 1;
        run_layer(2000, to);
        stall_en = 0;
        chk_cnt++;
        if (to || done_cnt != 1) begin
            err_cnt++; $display("FAIL stall_done: timeout=%b pulses=%0d, required 0 1", to, done_cnt);
        end
        chk_cnt++;
        if (writes != 12 || reads != 14 || wr_q.size() != 0) begin
            err_cnt++; $display("FAIL stall_counts: writes=%0d reads=%0d pending=%0d, required 12 14 0", writes, reads, wr_q.size());
        end
    endtask

    task automatic test_zero_dim();
        bit to;
        C = 11'd4; H = 11'd0; W = 11'd5;
        bias_v.delete(); acc_v.delete();
        build_expect();
        run_layer(50, to);
        chk_cnt++;
        if (to || done_cnt != 1) begin
            err_cnt++; $display("FAIL zero_done: timeout=%b pulses=%0d, required 0 1", to, done_cnt);
        end
        chk_cnt++;
        if (reads != 0 || writes != 0) begin
            err_cnt++; $display("FAIL zero_traffic: reads=%0d writes=%0d, required 0 0", reads, writes);
        end
        // One IDLE cycle after the last reset edge, done in the next one.
        chk_cnt++;
        if (done_cyc - rel_cyc != 1) begin
            err_cnt++; $display("FAIL zero_latency: done after %0d edges, required 1", done_cyc - rel_cyc);
        end
    endtask

    task automatic test_reset_mid_sof();
        bit to, seen;
        C = 11'd1; H = 11'd2; W = 11'd2; shift = 5'd1;
        ifaddr = 27'h0005000; baddr = 27'h0000400; ofaddr = 27'h0006000;
        bias_v = '{16'd10};
        acc_v  = '{32'd100, 32'd200, 32'd300, 32'd400};
        build_expect();
        hold_w = 1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wvalid === 1'b1) begin seen = 1; break; end
        end
        chk_cnt++;
        if (!seen) begin err_cnt++; $display("FAIL midsof_reach: wvalid=%b, required 1", wvalid); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        hold_w = 0;
        chk_cnt++;
        if ({rvalid, wvalid, done} !== 3'b000 || raddr !== '0 || waddr !== '0 || wdata !== '0) begin
            err_cnt++; $display("FAIL midsof_clear: rv/wv/done=%b raddr=%h waddr=%h wdata=%h, required all 0", {rvalid, wvalid, done}, raddr, waddr, wdata);
        end
        chk_cnt++;
        if (dut.state !== S_IDLE) begin
            err_cnt++; $display("FAIL midsof_state: state=%0d, required %0d", dut.state, S_IDLE);
        end
        build_expect();
        run_layer(500, to);
        chk_cnt++;
        if (to || done_cnt != 1 || writes != 4 || wr_q.size() != 0) begin
            err_cnt++; $display("FAIL midsof_rerun: timeout=%b pulses=%0d writes=%0d, required 0 1 4", to, done_cnt, writes);
        end
    endtask

    task automatic test_wide_sum();
        bit to;
        C = 11'd1; H = 11'd1; W = 11'd1; shift = 5'd31;
        ifaddr = 27'h0007000; baddr = 27'h0000500; ofaddr = 27'h0008000;
        bias_v = '{16'h7FFF};
        acc_v  = '{32'h7FFF_FFFF};
        build_expect();
        run_layer(200, to);
        chk_cnt++;
        if (to || writes != 1 || wr_q.size() != 0) begin
            err_cnt++; $display("FAIL wide_sum: timeout=%b writes=%0d pending=%0d, required 0 1 0", to, writes, wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias_per_channel();
        test_stall();
        test_zero_dim();
        test_reset_mid_sof();
        test_wide_sum();
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
